// File: rtl/rl_sched_if.sv
// rl_sched_if -- control/data bundle for the rl_sched two-channel RL current stepper.
//
// Signals (the master drives the control side; the slave is the scheduler):
//   tick      timestep strobe, one-cycle pulse
//   clr_ovr   clears the sticky overrun flag
//   u0, u1    signed channel voltages, Q.8
//   i0, i1    signed channel currents
//   busy      step sequence in progress
//   done      one-cycle pulse, i0/i1 have just been updated
//   overrun   sticky, a tick arrived while busy
//   sat       sticky accumulator-saturation flag
interface rl_sched_if;
  logic               tick;
  logic               clr_ovr;
  logic signed [31:0] u0;
  logic signed [31:0] u1;
  logic signed [31:0] i0;
  logic signed [31:0] i1;
  logic               busy;
  logic               done;
  logic               overrun;
  logic               sat;

  modport master (
    output tick, clr_ovr, u0, u1,
    input  i0, i1, busy, done, overrun, sat
  );

  modport slave (
    input  tick, clr_ovr, u0, u1,
    output i0, i1, busy, done, overrun, sat
  );
endinterface

// File: rtl/rl_sched.sv
// rl_sched -- two-channel RL current integrator driven by a shared multiplier.
//
// Each tick advances both channel currents by one explicit-Euler step:
//   I += ((((u - R*I) >>> 8) * L_DIV * DT) >>> 10)
// Channel 0 is processed first, then channel 1, through a single signed
// 32x32 multiplier (low 32 bits kept). Tick-to-done latency is 13 edges.
//
// Ports:
//   clk   sole clock, rising edge
//   rst   synchronous active-high reset
//   bus   rl_sched_if.slave: tick, clr_ovr, u0, u1 in; i0, i1, busy, done,
//         overrun, sat out
//
// Configuration:
//   RL_SCHED_SAT_EN defined   -> accumulator clamps to 0x7FFFFFFF/0x80000000
//                                on overflow and sets the sticky sat flag
//   RL_SCHED_SAT_EN undefined -> accumulator wraps, sat is tied low
module rl_sched #(
  parameter logic signed [31:0] R     = 32'sd10,
  parameter logic signed [31:0] L_DIV = 32'sd1000,
  parameter logic signed [31:0] DT    = 32'sd26
) (
  input  logic       clk,
  input  logic       rst,
  rl_sched_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_M1   = 3'd2;
  localparam logic [2:0] S_SUB  = 3'd3;
  localparam logic [2:0] S_M2   = 3'd4;
  localparam logic [2:0] S_M3   = 3'd5;
  localparam logic [2:0] S_ACC  = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  logic [2:0]         r_state;
  logic               r_ch;
  logic signed [31:0] r_u;
  logic signed [31:0] r_p;
  logic signed [31:0] r_x;
  logic signed [31:0] r_acc [2];
  logic signed [31:0] r_i0;
  logic signed [31:0] r_i1;
  logic               r_done;
  logic               r_ovr;

  logic signed [31:0] w_cur;
  logic signed [31:0] w_mul_a;
  logic signed [31:0] w_mul_b;
  logic signed [31:0] w_prod;
  logic signed [31:0] w_diff;
  logic signed [31:0] w_inc;
  logic signed [31:0] w_sum;

  assign w_cur  = r_acc[r_ch];
  assign w_diff = r_u - r_p;
  assign w_inc  = r_p >>> 10;
  assign w_sum  = w_cur + w_inc;

  // Operand steering for the one shared multiplier; the 32-bit signed result
  // is exactly the low word of the full product.
  always_comb begin
    w_mul_a = R;
    w_mul_b = w_cur;
    case (r_state)
      S_M2: begin
        w_mul_a = r_x;
        w_mul_b = L_DIV;
      end
      S_M3: begin
        w_mul_a = r_p;
        w_mul_b = DT;
      end
      default: begin
        w_mul_a = R;
        w_mul_b = w_cur;
      end
    endcase
  end

  assign w_prod = w_mul_a * w_mul_b;

`ifdef RL_SCHED_SAT_EN
  logic r_sat;
  logic w_ovf;
  // Signed overflow: both addends share a sign that the sum does not.
  assign w_ovf = (w_cur[31] == w_inc[31]) && (w_sum[31] != w_cur[31]);
  assign bus.sat = r_sat;
`else
  assign bus.sat = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_ch     <= 1'b0;
      r_u      <= '0;
      r_p      <= '0;
      r_x      <= '0;
      r_acc[0] <= '0;
      r_acc[1] <= '0;
      r_i0     <= '0;
      r_i1     <= '0;
      r_done   <= 1'b0;
      r_ovr    <= 1'b0;
`ifdef RL_SCHED_SAT_EN
      r_sat    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;

      // A tick while busy wins over a simultaneous clear.
      if (bus.tick && (r_state != S_IDLE)) begin
        r_ovr <= 1'b1;
      end else if (bus.clr_ovr) begin
        r_ovr <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (bus.tick) begin
            r_ch    <= 1'b0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_u     <= r_ch ? bus.u1 : bus.u0;
          r_state <= S_M1;
        end
        S_M1: begin
          r_p     <= w_prod;
          r_state <= S_SUB;
        end
        S_SUB: begin
          r_x     <= w_diff >>> 8;
          r_state <= S_M2;
        end
        S_M2: begin
          r_p     <= w_prod;
          r_state <= S_M3;
        end
        S_M3: begin
          r_p     <= w_prod;
          r_state <= S_ACC;
        end
        S_ACC: begin
`ifdef RL_SCHED_SAT_EN
          if (w_ovf) begin
            r_acc[r_ch] <= w_cur[31] ? 32'sh80000000 : 32'sh7FFFFFFF;
            r_sat       <= 1'b1;
          end else begin
            r_acc[r_ch] <= w_sum;
          end
`else
          r_acc[r_ch] <= w_sum;
`endif
          if (!r_ch) begin
            r_ch    <= 1'b1;
            r_state <= S_LOAD;
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_i0    <= r_acc[0];
          r_i1    <= r_acc[1];
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = (r_state != S_IDLE);
  assign bus.done    = r_done;
  assign bus.overrun = r_ovr;
  assign bus.i0      = r_i0;
  assign bus.i1      = r_i1;

endmodule

// File: tb/tb_rl_sched.sv
// tb_rl_sched -- directed self-checking bench for rl_sched.
// Instance u_a uses default coefficients; u_b uses R=0, L_DIV=256, DT=1
// to drive the accumulator across the 32-bit boundary.
module tb_rl_sched;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  rl_sched_if if_a ();
  rl_sched_if if_b ();

  rl_sched u_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a)
  );

  rl_sched #(
    .R     (32'sd0),
    .L_DIV (32'sd256),
    .DT    (32'sd1)
  ) u_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d (0x%08h) expected=%0d (0x%08h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic do_reset(input logic with_tick);
    rst = 1'b1;
    if_a.tick = with_tick;
    if_b.tick = with_tick;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    if_a.tick = 1'b0;
    if_b.tick = 1'b0;
  endtask

  // One full step on u_a. An extra tick is issued at edge N+tick_k, and a
  // tick plus clr_ovr together at edge N+both_k (0 disables either). u0 is
  // scrambled after channel 0 has latched it and restored afterwards.
  task automatic run_a(input int tick_k, input int both_k);
    logic [31:0] saved;
    int lat;
    lat   = 0;
    saved = if_a.u0;
    if_a.tick = 1'b1;
    @(posedge clk);
    #1;
    if_a.tick = 1'b0;
    chk("busy_after_tick", {31'd0, if_a.busy}, 32'd1);
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if_a.tick    = (k == tick_k) || (k == both_k);
      if_a.clr_ovr = (k == both_k);
      if (k == 2) if_a.u0 = ~saved;
      @(posedge clk);
      #1;
      if_a.tick    = 1'b0;
      if_a.clr_ovr = 1'b0;
      if (if_a.done) lat = k;
    end
    if_a.u0 = saved;
    chk("latency", lat, 32'd13);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, if_a.done}, 32'd0);
    chk("busy_idle", {31'd0, if_a.busy}, 32'd0);
    $display("step: i0=%0d i1=%0d overrun=%0b latency=%0d", if_a.i0, if_a.i1, if_a.overrun, lat);
  endtask

  initial begin
    int tmo;
    int w;
    errors = 0;
    checks = 0;
    rst = 1'b1;
    if_a.tick = 1'b0; if_a.clr_ovr = 1'b0; if_a.u0 = '0; if_a.u1 = '0;
    if_b.tick = 1'b0; if_b.clr_ovr = 1'b0; if_b.u0 = '0; if_b.u1 = '0;

    // Reset with a coincident tick: nothing may start.
    do_reset(1'b1);
    chk("rst_i0", if_a.i0, 32'd0);
    chk("rst_i1", if_a.i1, 32'd0);
    chk("rst_busy", {31'd0, if_a.busy}, 32'd0);
    chk("rst_done", {31'd0, if_a.done}, 32'd0);
    chk("rst_overrun", {31'd0, if_a.overrun}, 32'd0);
    chk("rst_sat", {31'd0, if_a.sat}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst_tick_ignored", {31'd0, if_a.busy}, 32'd0);

    // First and second step from rest.
    if_a.u0 = 32'sd51200;
    if_a.u1 = 32'sd0;
    run_a(0, 0);
    chk("step1_i0", if_a.i0, 32'd5078);
    chk("step1_i1", if_a.i1, 32'd0);
    run_a(0, 0);
    chk("step2_i0", if_a.i0, 32'd5103);
    chk("step2_i1", if_a.i1, 32'd0);

    // Negative voltage: floor rounding of -5078.125.
    do_reset(1'b0);
    if_a.u0 = 32'sd0;
    if_a.u1 = -32'sd51200;
    run_a(0, 0);
    chk("neg_i0", if_a.i0, 32'd0);
    chk("neg_i1", if_a.i1, -32'sd5079);

    // Overrun: tick at N+5, tick+clr at N+8 keeps it set.
    do_reset(1'b0);
    if_a.u0 = 32'sd51200;
    if_a.u1 = 32'sd0;
    run_a(5, 8);
    chk("ovr_i0", if_a.i0, 32'd5078);
    chk("ovr_set", {31'd0, if_a.overrun}, 32'd1);
    if_a.clr_ovr = 1'b1;
    @(posedge clk);
    #1;
    if_a.clr_ovr = 1'b0;
    chk("ovr_cleared", {31'd0, if_a.overrun}, 32'd0);

    // Tick sampled in DONE is ignored and flags overrun.
    run_a(13, 0);
    chk("done_tick_i0", if_a.i0, 32'd5103);
    chk("done_tick_ovr", {31'd0, if_a.overrun}, 32'd1);
    if_a.clr_ovr = 1'b1;
    @(posedge clk);
    #1;
    if_a.clr_ovr = 1'b0;

    // Reset while channel 1 is in M2 (entered at edge N+9).
    if_a.tick = 1'b1;
    @(posedge clk);
    #1;
    if_a.tick = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", {31'd0, if_a.busy}, 32'd0);
    chk("abort_i0", if_a.i0, 32'd0);
    chk("abort_i1", if_a.i1, 32'd0);
    chk("abort_ovr", {31'd0, if_a.overrun}, 32'd0);
    for (int c = 0; c < 6; c++) begin
      chk("abort_no_done", {31'd0, if_a.done}, 32'd0);
      @(posedge clk);
      #1;
    end
    run_a(0, 0);
    chk("after_abort_i0", if_a.i0, 32'd5078);
    chk("after_abort_i1", if_a.i1, 32'd0);

    // Accumulator boundary on u_b: +2097151 per tick.
    if_b.u0 = 32'sh7FFFFF00;
    if_b.u1 = 32'sd0;
    tmo = 0;
    for (int t = 1; t <= 1025; t++) begin
      if_b.tick = 1'b1;
      @(posedge clk);
      #1;
      if_b.tick = 1'b0;
      w = 0;
      while (!if_b.done && w < 20) begin
        @(posedge clk);
        #1;
        w++;
      end
      if (!if_b.done) tmo++;
      if (t == 1) chk("b_first_i0", if_b.i0, 32'd2097151);
      if (t == 1024) begin
        chk("b_pre_ovf_i0", if_b.i0, 32'h7FFFFC00);
        chk("b_pre_ovf_sat", {31'd0, if_b.sat}, 32'd0);
      end
    end
    chk("b_timeouts", tmo, 32'd0);
    chk("b_i1", if_b.i1, 32'd0);
`ifdef RL_SCHED_SAT_EN
    chk("b_ovf_i0", if_b.i0, 32'h7FFFFFFF);
    chk("b_ovf_sat", {31'd0, if_b.sat}, 32'd1);
`else
    // 0x7FFFFC00 + 0x1FFFFF wrapped = -2145387521
    chk("b_ovf_i0", if_b.i0, 32'h801FFBFF);
    chk("b_ovf_sat", {31'd0, if_b.sat}, 32'd0);
`endif
    $display("boundary: i0=%0d sat=%0b", if_b.i0, if_b.sat);
    chk("a_sat", {31'd0, if_a.sat}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
